mouse_tracker_core: RTL and testbench

Parametrised PS/2 mouse event processor placed between the `mouse` interface and the display blocks (`led_controller`, VGA text). It takes decoded movement packets, tracks an absolute cursor position clamped to a screen window, and counts button presses per channel. It optionally accumulates a scroll-wheel axis. It generalises the fixed 3-button, unbounded X/Y accumulation used today to N buttons, arbitrary screen bounds and widths, and overflow-aware packet handling.

---
 rtl/mouse_tracker_core.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_mouse_tracker_core.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_tracker_core.sv
// -----------------------------------------------------------------------------
// mouse_tracker_core
//
// PS/2 mouse event processor. Takes decoded movement packets, keeps an
// absolute cursor position clamped to a screen window, counts button presses
// per channel and optionally accumulates a scroll-wheel axis.
//
// Two-stage pipeline:
//   S1 registers the packet fields on a cycle with pkt_valid=1.
//   S2 does the arithmetic and loads every output register.
// A strobe sampled at edge E is visible on the outputs after edge E+1.
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active-low (release is synchronous)
//   clr        synchronous clear, active-high, wins over pkt_valid
//   pkt_valid  one-cycle packet strobe
//   dx, dy     9-bit two's complement deltas (dy positive = up)
//   x_ovf      X overflow flag, freezes X for this packet
//   y_ovf      Y overflow flag, freezes Y for this packet
//   btn        button levels, 1 = pressed
//   dz         4-bit two's complement wheel delta
//   pos_x      cursor X, 0..X_MAX
//   pos_y      cursor Y, 0..Y_MAX, 0 = top of screen
//   wheel      signed saturating wheel accumulator (0 when WHEEL_EN=0)
//   btn_state  button levels from the last update
//   press      one-cycle press pulses
//   btn_cnt    packed press counters, channel i at [i*CNT_W +: CNT_W]
//   clamp      {y_clamped, x_clamped} of the last update
//   upd_valid  one-cycle strobe: outputs hold a new update
// -----------------------------------------------------------------------------
module mouse_tracker_core #(
    parameter int X_W      = 10,
    parameter int Y_W      = 10,
    parameter int X_MAX    = 639,
    parameter int Y_MAX    = 479,
    parameter int X_HOME   = 320,
    parameter int Y_HOME   = 240,
    parameter int NBTN     = 3,
    parameter int CNT_W    = 8,
    parameter int CNT_SAT  = 1,
    parameter int WHEEL_EN = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    pkt_valid,
    input  logic [8:0]              dx,
    input  logic [8:0]              dy,
    input  logic                    x_ovf,
    input  logic                    y_ovf,
    input  logic [NBTN-1:0]         btn,
    input  logic [3:0]              dz,
    output logic [X_W-1:0]          pos_x,
    output logic [Y_W-1:0]          pos_y,
    output logic [15:0]             wheel,
    output logic [NBTN-1:0]         btn_state,
    output logic [NBTN-1:0]         press,
    output logic [NBTN*CNT_W-1:0]   btn_cnt,
    output logic [1:0]              clamp,
    output logic                    upd_valid
);

    // Arithmetic width: two guard bits above the position width. For very
    // narrow positions the 9-bit delta would not fit, so never go below 10.
    localparam int XS = (X_W + 2 > 10) ? X_W + 2 : 10;
    localparam int YS = (Y_W + 2 > 10) ? Y_W + 2 : 10;

    localparam logic signed [XS-1:0] X_MAX_S  = XS'(X_MAX);
    localparam logic signed [YS-1:0] Y_MAX_S  = YS'(Y_MAX);
    localparam logic [X_W-1:0]       X_HOME_V = X_W'(X_HOME);
    localparam logic [Y_W-1:0]       Y_HOME_V = Y_W'(Y_HOME);
    localparam logic [X_W-1:0]       X_MAX_V  = X_W'(X_MAX);
    localparam logic [Y_W-1:0]       Y_MAX_V  = Y_W'(Y_MAX);

    // ------------------------------------------------------------------
    // S1: packet capture
    // ------------------------------------------------------------------
    logic            s1_valid_q, s1_valid_d;
    logic [8:0]      s1_dx_q, s1_dx_d;
    logic [8:0]      s1_dy_q, s1_dy_d;
    logic            s1_xovf_q, s1_xovf_d;
    logic            s1_yovf_q, s1_yovf_d;
    logic [NBTN-1:0] s1_btn_q, s1_btn_d;
    logic [3:0]      s1_dz_q, s1_dz_d;

    always_comb begin
        // clr also kills a packet sampled in the same cycle
        s1_valid_d = pkt_valid & ~clr;
        s1_dx_d    = s1_dx_q;
        s1_dy_d    = s1_dy_q;
        s1_xovf_d  = s1_xovf_q;
        s1_yovf_d  = s1_yovf_q;
        s1_btn_d   = s1_btn_q;
        s1_dz_d    = s1_dz_q;
        if (pkt_valid) begin
            s1_dx_d   = dx;
            s1_dy_d   = dy;
            s1_xovf_d = x_ovf;
            s1_yovf_d = y_ovf;
            s1_btn_d  = btn;
            s1_dz_d   = dz;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_dx_q    <= '0;
            s1_dy_q    <= '0;
            s1_xovf_q  <= 1'b0;
            s1_yovf_q  <= 1'b0;
            s1_btn_q   <= '0;
            s1_dz_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_dx_q    <= s1_dx_d;
            s1_dy_q    <= s1_dy_d;
            s1_xovf_q  <= s1_xovf_d;
            s1_yovf_q  <= s1_yovf_d;
            s1_btn_q   <= s1_btn_d;
            s1_dz_q    <= s1_dz_d;
        end
    end

    // ------------------------------------------------------------------
    // S2 state
    // ------------------------------------------------------------------
    logic [X_W-1:0]        pos_x_q, pos_x_d;
    logic [Y_W-1:0]        pos_y_q, pos_y_d;
    logic [15:0]           wheel_q, wheel_d;
    logic [NBTN-1:0]       btn_state_q, btn_state_d;
    logic [NBTN-1:0]       press_q, press_d;
    logic [NBTN*CNT_W-1:0] btn_cnt_q, btn_cnt_d;
    logic [1:0]            clamp_q, clamp_d;
    logic                  upd_valid_q, upd_valid_d;

    // ------------------------------------------------------------------
    // X axis: pos_x + dx, clamped to [0, X_MAX]
    // ------------------------------------------------------------------
    logic signed [XS-1:0] x_sum;
    logic [X_W-1:0]       x_new;
    logic                 x_clamped;

    always_comb begin
        x_sum = $signed({{(XS-X_W){1'b0}}, pos_x_q})
              + $signed({{(XS-9){s1_dx_q[8]}}, s1_dx_q});
        x_new     = x_sum[X_W-1:0];
        x_clamped = 1'b0;
        if (s1_xovf_q) begin
            x_new = pos_x_q;
        end else if (x_sum[XS-1]) begin
            x_new     = '0;
            x_clamped = 1'b1;
        end else if (x_sum > X_MAX_S) begin
            x_new     = X_MAX_V;
            x_clamped = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Y axis: screen Y grows downward, so a positive (up) dy is subtracted
    // ------------------------------------------------------------------
    logic signed [YS-1:0] y_sum;
    logic [Y_W-1:0]       y_new;
    logic                 y_clamped;

    always_comb begin
        y_sum = $signed({{(YS-Y_W){1'b0}}, pos_y_q})
              - $signed({{(YS-9){s1_dy_q[8]}}, s1_dy_q});
        y_new     = y_sum[Y_W-1:0];
        y_clamped = 1'b0;
        if (s1_yovf_q) begin
            y_new = pos_y_q;
        end else if (y_sum[YS-1]) begin
            y_new     = '0;
            y_clamped = 1'b1;
        end else if (y_sum > Y_MAX_S) begin
            y_new     = Y_MAX_V;
            y_clamped = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Wheel: 17-bit sum; bits 16 and 15 disagree exactly on overflow,
    // and bit 16 then gives the direction to saturate toward.
    // ------------------------------------------------------------------
    logic [16:0] w_sum;
    logic [15:0] wheel_new;

    always_comb begin
        w_sum     = {wheel_q[15], wheel_q} + {{13{s1_dz_q[3]}}, s1_dz_q};
        wheel_new = '0;
        if (WHEEL_EN != 0) begin
            if (w_sum[16] != w_sum[15]) begin
                wheel_new = w_sum[16] ? 16'h8000 : 16'h7FFF;
            end else begin
                wheel_new = w_sum[15:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Buttons: press = rising level relative to the last update
    // ------------------------------------------------------------------
    logic [NBTN-1:0]       press_new;
    logic [NBTN*CNT_W-1:0] cnt_new;

    generate
        for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
            logic [CNT_W-1:0] cnt_cur;
            logic [CNT_W-1:0] cnt_nxt;

            assign cnt_cur       = btn_cnt_q[gi*CNT_W +: CNT_W];
            assign press_new[gi] = s1_btn_q[gi] & ~btn_state_q[gi];

            always_comb begin
                cnt_nxt = cnt_cur;
                if (press_new[gi]) begin
                    if ((CNT_SAT != 0) && (&cnt_cur)) begin
                        cnt_nxt = cnt_cur;
                    end else begin
                        cnt_nxt = cnt_cur + 1'b1;
                    end
                end
            end

            assign cnt_new[gi*CNT_W +: CNT_W] = cnt_nxt;
        end
    endgenerate

    // ------------------------------------------------------------------
    // S2 next-state: clear > update > hold
    // ------------------------------------------------------------------
    always_comb begin
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        wheel_d     = wheel_q;
        btn_state_d = btn_state_q;
        btn_cnt_d   = btn_cnt_q;
        clamp_d     = clamp_q;
        press_d     = '0;
        upd_valid_d = 1'b0;
        if (clr) begin
            pos_x_d     = X_HOME_V;
            pos_y_d     = Y_HOME_V;
            wheel_d     = '0;
            btn_state_d = '0;
            btn_cnt_d   = '0;
            clamp_d     = '0;
        end else if (s1_valid_q) begin
            pos_x_d     = x_new;
            pos_y_d     = y_new;
            wheel_d     = wheel_new;
            btn_state_d = s1_btn_q;
            btn_cnt_d   = cnt_new;
            clamp_d     = {y_clamped, x_clamped};
            press_d     = press_new;
            upd_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_x_q     <= X_HOME_V;
            pos_y_q     <= Y_HOME_V;
            wheel_q     <= '0;
            btn_state_q <= '0;
            press_q     <= '0;
            btn_cnt_q   <= '0;
            clamp_q     <= '0;
            upd_valid_q <= 1'b0;
        end else begin
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            wheel_q     <= wheel_d;
            btn_state_q <= btn_state_d;
            press_q     <= press_d;
            btn_cnt_q   <= btn_cnt_d;
            clamp_q     <= clamp_d;
            upd_valid_q <= upd_valid_d;
        end
    end

    assign pos_x     = pos_x_q;
    assign pos_y     = pos_y_q;
    assign wheel     = wheel_q;
    assign btn_state = btn_state_q;
    assign press     = press_q;
    assign btn_cnt   = btn_cnt_q;
    assign clamp     = clamp_q;
    assign upd_valid = upd_valid_q;

endmodule

// File: tb/tb_mouse_tracker_core.sv
// -----------------------------------------------------------------------------
// Bench for mouse_tracker_core. Three instances share one stimulus stream:
//   d0: defaults (8-bit saturating counters, no wheel)
//   d1: CNT_W=2, saturating counters, wheel enabled
//   d2: CNT_W=2, wrapping counters, no wheel
// Expected results are queued when a packet is issued; a monitor pops one
// entry per upd_valid and compares every output of all three instances.
// -----------------------------------------------------------------------------
module tb_mouse_tracker_core;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic       pkt_valid = 1'b0;
    logic [8:0] dx = '0;
    logic [8:0] dy = '0;
    logic       x_ovf = 1'b0;
    logic       y_ovf = 1'b0;
    logic [2:0] btn = '0;
    logic [3:0] dz = '0;

    logic [9:0]  px0, py0, px1, py1, px2, py2;
    logic [15:0] w0, w1, w2;
    logic [2:0]  bs0, bs1, bs2, pr0, pr1, pr2;
    logic [23:0] cn0;
    logic [5:0]  cn1, cn2;
    logic [1:0]  cl0, cl1, cl2;
    logic        uv0, uv1, uv2;

    always #5 clk = ~clk;

    mouse_tracker_core d0 (
        .clk(clk), .rst(rst), .clr(clr), .pkt_valid(pkt_valid),
        .dx(dx), .dy(dy), .x_ovf(x_ovf), .y_ovf(y_ovf), .btn(btn), .dz(dz),
        .pos_x(px0), .pos_y(py0), .wheel(w0), .btn_state(bs0), .press(pr0),
        .btn_cnt(cn0), .clamp(cl0), .upd_valid(uv0)
    );

    mouse_tracker_core #(.CNT_W(2), .CNT_SAT(1), .WHEEL_EN(1)) d1 (
        .clk(clk), .rst(rst), .clr(clr), .pkt_valid(pkt_valid),
        .dx(dx), .dy(dy), .x_ovf(x_ovf), .y_ovf(y_ovf), .btn(btn), .dz(dz),
        .pos_x(px1), .pos_y(py1), .wheel(w1), .btn_state(bs1), .press(pr1),
        .btn_cnt(cn1), .clamp(cl1), .upd_valid(uv1)
    );

    mouse_tracker_core #(.CNT_W(2), .CNT_SAT(0), .WHEEL_EN(0)) d2 (
        .clk(clk), .rst(rst), .clr(clr), .pkt_valid(pkt_valid),
        .dx(dx), .dy(dy), .x_ovf(x_ovf), .y_ovf(y_ovf), .btn(btn), .dz(dz),
        .pos_x(px2), .pos_y(py2), .wheel(w2), .btn_state(bs2), .press(pr2),
        .btn_cnt(cn2), .clamp(cl2), .upd_valid(uv2)
    );

    typedef struct {
        logic [9:0]  px;
        logic [9:0]  py;
        logic [1:0]  cl;
        logic [2:0]  pr;
        logic [2:0]  bs;
        logic [23:0] c0;
        logic [5:0]  c1;
        logic [5:0]  c2;
        logic [15:0] w1;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;
    int   ntx = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // n0/n1: d0 counts of channels 0/1; s0: d1 channel 0; r0: d2 channel 0
    function automatic exp_t mk(input int px, input int py, input logic [1:0] cl,
                                input logic [2:0] pr, input logic [2:0] bs,
                                input int n0, input int n1, input int s0,
                                input int r0, input int w);
        exp_t x;
        x.px = px[9:0];
        x.py = py[9:0];
        x.cl = cl;
        x.pr = pr;
        x.bs = bs;
        x.c0 = {8'd0, n1[7:0], n0[7:0]};
        x.c1 = {2'b00, n1[1:0], s0[1:0]};
        x.c2 = {2'b00, n1[1:0], r0[1:0]};
        x.w1 = w[15:0];
        return x;
    endfunction

    task automatic send(input logic [8:0] dxi, input logic [8:0] dyi,
                        input logic xo, input logic yo, input logic [2:0] b,
                        input logic [3:0] dzi, input exp_t ex);
        dx = dxi; dy = dyi; x_ovf = xo; y_ovf = yo; btn = b; dz = dzi;
        pkt_valid = 1'b1;
        q.push_back(ex);
        @(posedge clk); #1;
        pkt_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: one queue entry per update, checked across all instances
    always @(negedge clk) begin
        if (mon_en) begin
            if (uv0 || uv1 || uv2) begin
                chk("upd_valid_agree", {29'd0, uv0, uv1, uv2}, 32'h7);
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_update actual=upd_valid=1 required=no update pending");
                end else begin
                    e = q.pop_front();
                    ntx++;
                    $display("txn %0d px=%0d py=%0d clamp=%b press=%b btn_state=%b cnt0=%h cnt1=%h cnt2=%h wheel1=%0d",
                             ntx, px0, py0, cl0, pr0, bs0, cn0, cn1, cn2, $signed(w1));
                    chk("pos_x_d0", 32'(px0), 32'(e.px));
                    chk("pos_y_d0", 32'(py0), 32'(e.py));
                    chk("pos_x_d1", 32'(px1), 32'(e.px));
                    chk("pos_y_d1", 32'(py1), 32'(e.py));
                    chk("pos_x_d2", 32'(px2), 32'(e.px));
                    chk("pos_y_d2", 32'(py2), 32'(e.py));
                    chk("clamp_d0", 32'(cl0), 32'(e.cl));
                    chk("clamp_d1", 32'(cl1), 32'(e.cl));
                    chk("press_d0", 32'(pr0), 32'(e.pr));
                    chk("press_d2", 32'(pr2), 32'(e.pr));
                    chk("btn_state_d0", 32'(bs0), 32'(e.bs));
                    chk("btn_state_d1", 32'(bs1), 32'(e.bs));
                    chk("btn_cnt_d0", 32'(cn0), 32'(e.c0));
                    chk("btn_cnt_d1", 32'(cn1), 32'(e.c1));
                    chk("btn_cnt_d2", 32'(cn2), 32'(e.c2));
                    chk("wheel_d0", 32'(w0), 32'd0);
                    chk("wheel_d1", 32'(w1), 32'(e.w1));
                    chk("wheel_d2", 32'(w2), 32'd0);
                end
            end else begin
                chk("press_idle", {23'd0, pr0, pr1, pr2}, 32'd0);
            end
        end
    end

    task automatic check_home(input string tag);
        chk({tag, "_pos_x"}, 32'(px0), 32'd320);
        chk({tag, "_pos_y"}, 32'(py0), 32'd240);
        chk({tag, "_pos_x_d1"}, 32'(px1), 32'd320);
        chk({tag, "_wheel"}, {w0, w1}, 32'd0);
        chk({tag, "_btn_state"}, {26'd0, bs0, bs1}, 32'd0);
        chk({tag, "_press"}, {26'd0, pr0, pr2}, 32'd0);
        chk({tag, "_btn_cnt_d0"}, 32'(cn0), 32'd0);
        chk({tag, "_btn_cnt_d12"}, {20'd0, cn1, cn2}, 32'd0);
        chk({tag, "_clamp"}, {28'd0, cl0, cl1}, 32'd0);
        chk({tag, "_upd_valid"}, {29'd0, uv0, uv1, uv2}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        #12;
        check_home("reset_held");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_home("reset_released");
        mon_en = 1'b1;

        // basic move
        send(9'd5, 9'd3, 0, 0, 3'b000, 4'd0, mk(325, 237, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        idle(3);
        // back-to-back toward the right edge
        send(9'd255, 9'd0, 0, 0, 3'b000, 4'd0, mk(580, 237, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        send(9'd55,  9'd0, 0, 0, 3'b000, 4'd0, mk(635, 237, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        idle(3);
        send(9'd20,  9'd0, 0, 0, 3'b000, 4'd0, mk(639, 237, 2'b01, 0, 0, 0, 0, 0, 0, 0));
        send(9'h101, 9'd0, 0, 0, 3'b000, 4'd0, mk(384, 237, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        send(9'h101, 9'd0, 0, 0, 3'b000, 4'd0, mk(129, 237, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        send(9'h101, 9'd0, 0, 0, 3'b000, 4'd0, mk(0,   237, 2'b01, 0, 0, 0, 0, 0, 0, 0));
        idle(3);
        // X overflow freezes X only
        send(9'd100, 9'h1F6, 1, 0, 3'b000, 4'd0, mk(0, 247, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        // Y clamps
        send(9'd0, 9'd255, 0, 0, 3'b000, 4'd0, mk(0, 0,   2'b10, 0, 0, 0, 0, 0, 0, 0));
        send(9'd0, 9'h101, 0, 0, 3'b000, 4'd0, mk(0, 255, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        send(9'd0, 9'h101, 0, 0, 3'b000, 4'd0, mk(0, 479, 2'b10, 0, 0, 0, 0, 0, 0, 0));
        // Y overflow freezes Y only
        send(9'd10, 9'd5, 0, 1, 3'b000, 4'd0, mk(10, 479, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        idle(3);
        // buttons
        send(9'd0, 9'd0, 0, 0, 3'b001, 4'd0, mk(10, 479, 2'b00, 3'b001, 3'b001, 1, 0, 1, 1, 0));
        send(9'd0, 9'd0, 0, 0, 3'b001, 4'd0, mk(10, 479, 2'b00, 3'b000, 3'b001, 1, 0, 1, 1, 0));
        send(9'd0, 9'd0, 0, 0, 3'b000, 4'd0, mk(10, 479, 2'b00, 3'b000, 3'b000, 1, 0, 1, 1, 0));
        send(9'd0, 9'd0, 0, 0, 3'b001, 4'd0, mk(10, 479, 2'b00, 3'b001, 3'b001, 2, 0, 2, 2, 0));
        send(9'd0, 9'd0, 0, 0, 3'b011, 4'd0, mk(10, 479, 2'b00, 3'b010, 3'b011, 2, 1, 2, 2, 0));
        send(9'd0, 9'd0, 0, 0, 3'b000, 4'd0, mk(10, 479, 2'b00, 3'b000, 3'b000, 2, 1, 2, 2, 0));
        send(9'd0, 9'd0, 0, 0, 3'b001, 4'd0, mk(10, 479, 2'b00, 3'b001, 3'b001, 3, 1, 3, 3, 0));
        send(9'd0, 9'd0, 0, 0, 3'b000, 4'd0, mk(10, 479, 2'b00, 3'b000, 3'b000, 3, 1, 3, 3, 0));
        send(9'd0, 9'd0, 0, 0, 3'b001, 4'd0, mk(10, 479, 2'b00, 3'b001, 3'b001, 4, 1, 3, 0, 0));
        send(9'd0, 9'd0, 0, 0, 3'b000, 4'd0, mk(10, 479, 2'b00, 3'b000, 3'b000, 4, 1, 3, 0, 0));
        send(9'd0, 9'd0, 0, 0, 3'b001, 4'd0, mk(10, 479, 2'b00, 3'b001, 3'b001, 5, 1, 3, 1, 0));
        idle(4);
        chk("queue_drained_before_clr", 32'(q.size()), 32'd0);

        // clear with a packet in S1 and another sampled in the same cycle
        dx = 9'd7; dy = 9'd0; btn = 3'b000; pkt_valid = 1'b1;
        @(posedge clk); #1;
        clr = 1'b1; dx = 9'd50; pkt_valid = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; pkt_valid = 1'b0;
        idle(4);
        check_home("after_clr");

        // wheel saturation at -32768
        for (int k = 1; k <= 4097; k++) begin
            w = -8 * k;
            if (w < -32768) w = -32768;
            send(9'd0, 9'd0, 0, 0, 3'b000, 4'h8, mk(320, 240, 2'b00, 0, 0, 0, 0, 0, 0, w));
        end
        send(9'd0, 9'd0, 0, 0, 3'b000, 4'h1, mk(320, 240, 2'b00, 0, 0, 0, 0, 0, 0, -32767));

        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("queue_drained_at_end", 32'(q.size()), 32'd0);
        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
